// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide responder, one bit per clock
// Optional early-out short paths are enabled by defining MULDIV_EARLY_OUT_EN.

module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int HW = WIDTH / 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_MULH = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_REM  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;      // 1: restoring divide, 0: shift-add multiply
    logic             op_rem;      // divide flavour: 1 returns the remainder
    logic [WIDTH-1:0] opa;         // multiplicand (shifted left) / dividend-quotient shifter
    logic [WIDTH-1:0] opb;         // multiplier (shifted right) / divisor
    logic [WIDTH-1:0] acc;         // product accumulator / partial remainder
    logic             short_path;
    logic [WIDTH-1:0] short_res;

    // Accept-time decode: initial operands and whether the request short-circuits
    logic [WIDTH-1:0] a_init, b_init, s_res;
    logic             s_short, s_div, s_rem;

    // Accept decode of the incoming request into operand setup and short-path result
    always_comb begin
        a_init  = X;
        b_init  = Y;
        s_res   = '0;
        s_short = 1'b0;
        s_div   = 1'b0;
        s_rem   = 1'b0;
        case (S)
            OP_MUL: begin
`ifdef MULDIV_EARLY_OUT_EN
                if (X == '0 || Y == '0) s_short = 1'b1;
`endif
            end
            OP_MULH: begin
                a_init = {{HW{1'b0}}, X[WIDTH-1:HW]};
                b_init = {{HW{1'b0}}, Y[WIDTH-1:HW]};
`ifdef MULDIV_EARLY_OUT_EN
                if (X[WIDTH-1:HW] == '0 || Y[WIDTH-1:HW] == '0) s_short = 1'b1;
`endif
            end
            OP_DIV, OP_REM: begin
                s_div = 1'b1;
                s_rem = (S == OP_REM);
                if (Y == '0) begin
                    // RISC-V divide-by-zero: all-ones quotient, dividend as remainder
                    s_short = 1'b1;
                    s_res   = s_rem ? X : '1;
                end
`ifdef MULDIV_EARLY_OUT_EN
                else if (X < Y) begin
                    s_short = 1'b1;
                    s_res   = s_rem ? X : '0;
                end
`endif
            end
            default: begin
                s_short = 1'b1;
                s_res   = '0;
            end
        endcase
    end

    // One iteration of either datapath, evaluated from the current registers
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;

    // Single-bit step: shift-add for multiply, shift-compare-subtract for divide
    always_comb begin
        rem_sh = {acc, opa[WIDTH-1]};
        rem_ge = (rem_sh >= {1'b0, opb});
        if (op_div) begin
            acc_n = rem_ge ? WIDTH'(rem_sh - {1'b0, opb}) : rem_sh[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], rem_ge};
            opb_n = opb;
        end else begin
            acc_n = acc + (opb[0] ? opa : '0);
            opa_n = {opa[WIDTH-2:0], 1'b0};
            opb_n = {1'b0, opb[WIDTH-1:1]};
        end
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_div     <= 1'b0;
            op_rem     <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            short_path <= 1'b0;
            short_res  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa        <= a_init;
                        opb        <= b_init;
                        acc        <= '0;
                        op_div     <= s_div;
                        op_rem     <= s_rem;
                        short_path <= s_short;
                        short_res  <= s_res;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (short_path) begin
                        result <= short_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc <= acc_n;
                        opa <= opa_n;
                        opb <= opb_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            if (op_div) result <= op_rem ? acc_n : opa_n;
                            else        result <= acc_n;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed table-driven bench for muldiv_seq

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [3:0]  S = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 32;
`endif

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .X      (X),
        .Y      (Y),
        .S      (S),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  s;
        logic [31:0] res;
        int          lat;
        bit          early;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, optionally poke a second start while busy, and check the completion
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] s, input logic [31:0] exp_res, input int exp_lat,
                          input int intrude_at);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; X = x; Y = y; S = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = $urandom; Y = $urandom; S = 4'b1001;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (k == intrude_at) begin
                start = 1'b1; X = 32'd2; Y = 32'd2; S = 4'b1001;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
        @(posedge clk);
        #1;
        check({name, " done drop"}, {31'd0, done}, 32'd0);
        check({name, " busy drop"}, {31'd0, busy}, 32'd0);
        check({name, " result hold"}, result, exp_res);
    endtask

    vec_t vecs[$];

    initial begin
        int extra_done;

        vecs.push_back('{32'h0001_0003, 32'h0000_0010, 4'b0111, 32'h0010_0030, 32, 1'b0});
        vecs.push_back('{32'hFFFF_0000, 32'hFFFF_0000, 4'b1000, 32'hFFFE_0001, 32, 1'b0});
        vecs.push_back('{32'hFFFF_0000, 32'hFFFF_0000, 4'b0111, 32'h0000_0000, 32, 1'b0});
        vecs.push_back('{32'd100,       32'd7,         4'b1001, 32'd14,        32, 1'b0});
        vecs.push_back('{32'd100,       32'd7,         4'b1010, 32'd2,         32, 1'b0});
        vecs.push_back('{32'd9,         32'd0,         4'b1001, 32'hFFFF_FFFF, 1,  1'b0});
        vecs.push_back('{32'd9,         32'd0,         4'b1010, 32'd9,         1,  1'b0});
        vecs.push_back('{32'd9,         32'd0,         4'b0011, 32'd0,         1,  1'b0});
        vecs.push_back('{32'd9,         32'd5,         4'b1111, 32'd0,         1,  1'b0});
        vecs.push_back('{32'd3,         32'd10,        4'b1010, 32'd3,         32, 1'b1});
        vecs.push_back('{32'd3,         32'd10,        4'b1001, 32'd0,         32, 1'b1});
        vecs.push_back('{32'd0,         32'd5,         4'b0111, 32'd0,         32, 1'b1});
        vecs.push_back('{32'h0000_FFFF, 32'h1234_0000, 4'b1000, 32'd0,         32, 1'b1});
        vecs.push_back('{32'h0000_FFFF, 32'h1234_0000, 4'b0111, 32'hEDCC_0000, 32, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1,         4'b1001, 32'hFFFF_FFFF, 32, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1,         4'b1010, 32'd0,         32, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 32'd1,         32, 1'b0});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors, issued back-to-back
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].res,
                   vecs[i].early ? EARLY_LAT : vecs[i].lat, 0);
        end

        // Start while busy: second request must be dropped, not queued
        run_op("intrude", 32'd6, 32'd7, 4'b0111, 32'd42, 32, 5);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("intrude no queued done", 32'(extra_done), 32'd0);

        // Reset mid-operation aborts with no done pulse
        @(negedge clk);
        start = 1'b1; X = 32'd5; Y = 32'd7; S = 4'b0111;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("midreset no done", 32'(extra_done), 32'd0);

        // Recovery after reset
        run_op("post reset", 32'd100, 32'd7, 4'b1001, 32'd14, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
